// File: rtl/spi_frame_pkg.sv
// Shared state encodings, CRC-8 constants and width helpers for the SPI frame transmitter.
// The CRC state code is only meaningful when SPI_FRAME_CRC8_EN is defined.
package spi_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ARMED = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_CRC   = 3'd5;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Word index needs at least one bit even for a single-word frame.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bit_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/spi_frame_tx_slave_crc8.sv
// Bit-serial CRC-8 accumulator (poly 0x07, MSB-first shift), one bit per enabled sclk edge.
// Clear takes priority over enable.
module spi_crc8_serial
    import spi_frame_pkg::*;
(
    input  logic       sclk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc_out
);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            crc_out <= CRC8_INIT;
        end else if (clear) begin
            crc_out <= CRC8_INIT;
        end else if (enable) begin
            crc_out <= crc8_step(crc_out, bit_in);
        end
    end

endmodule

// File: rtl/spi_frame_tx_slave.sv
// SPI slave frame transmitter: snapshots a NUM_WORDS x WORD_W frame and streams it on miso while cs is low.
// Optional trailing CRC-8 over the data bits is enabled with the SPI_FRAME_CRC8_EN macro.
module spi_frame_tx_slave
    import spi_frame_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int NUM_WORDS  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                        sclk,
    input  logic                        rst,
    input  logic                        cs,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] frame_in,
    output logic                        miso,
    output logic                        miso_oe,
    output logic                        busy,
    output logic                        data_ready
);

    localparam int BW = bit_width(WORD_W);
    localparam int IW = idx_width(NUM_WORDS);
    localparam int FW = NUM_WORDS * WORD_W;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [IW-1:0] WORD_LAST = IW'(NUM_WORDS - 1);
    localparam logic [3:0]    GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    // Handshake: a frame is captured on any posedge where load_valid && load_ready;
    // load_ready is high exactly while idle, so the buffer cannot change mid-frame.
    state_t          state;
    logic [FW-1:0]   frame_buf;
    logic [WORD_W-1:0] shift_reg;
    logic [BW-1:0]   bit_cnt;
    logic [IW-1:0]   word_idx;
    logic [IW-1:0]   nxt_idx;
    logic [3:0]      gap_cnt;
    logic [WORD_W-1:0] words [NUM_WORDS];

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
        assign words[g] = frame_buf[g*WORD_W +: WORD_W];
    end

    assign nxt_idx    = (word_idx == WORD_LAST) ? '0 : word_idx + 1'b1;
    assign load_ready = (state == ST_IDLE);

    function automatic logic first_bit(input logic [WORD_W-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WORD_W-1];
    endfunction

    function automatic logic [WORD_W-1:0] shifted(input logic [WORD_W-1:0] w);
        return (LSB_FIRST != 0) ? {1'b0, w[WORD_W-1:1]} : {w[WORD_W-2:0], 1'b0};
    endfunction

`ifdef SPI_FRAME_CRC8_EN
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc_val;
    logic [7:0] crc_nxt;
    logic [7:0] crc_sr;
    logic       crc_phase;

    // The CRC absorbs each data bit on the edge that retires it from miso.
    assign crc_clr = (state == ST_IDLE && load_valid) ||
                     (cs && (state == ST_GAP || state == ST_SHIFT || state == ST_CRC));
    assign crc_en  = (state == ST_SHIFT);
    assign crc_nxt = crc8_step(crc_val, miso);

    spi_crc8_serial u_crc (
        .sclk    (sclk),
        .rst     (rst),
        .clear   (crc_clr),
        .enable  (crc_en),
        .bit_in  (miso),
        .crc_out (crc_val)
    );
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_buf  <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            word_idx   <= '0;
            gap_cnt    <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
`ifdef SPI_FRAME_CRC8_EN
            crc_sr     <= '0;
            crc_phase  <= 1'b0;
`endif
        end else begin
            data_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    if (load_valid) begin
                        frame_buf <= frame_in;
                        busy      <= 1'b1;
                        state     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    if (!cs) begin
                        word_idx <= '0;
                        gap_cnt  <= '0;
                        bit_cnt  <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= ST_GAP;
                        end else begin
                            miso      <= first_bit(words[0]);
                            miso_oe   <= 1'b1;
                            shift_reg <= shifted(words[0]);
                            state     <= ST_SHIFT;
                        end
                    end
                end
                ST_GAP, ST_SHIFT, ST_CRC: begin
                    if (cs) begin
                        // Abort: keep the buffer, rewind so the next cs low restarts at word 0.
                        state    <= ST_ARMED;
                        miso     <= 1'b0;
                        miso_oe  <= 1'b0;
                        word_idx <= '0;
                        gap_cnt  <= '0;
                        bit_cnt  <= '0;
`ifdef SPI_FRAME_CRC8_EN
                        crc_phase <= 1'b0;
`endif
                    end else if (state == ST_GAP) begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        if (gap_cnt == GAP_LAST) begin
                            bit_cnt <= '0;
                            miso_oe <= 1'b1;
`ifdef SPI_FRAME_CRC8_EN
                            if (crc_phase) begin
                                miso   <= crc_val[7];
                                crc_sr <= {crc_val[6:0], 1'b0};
                                state  <= ST_CRC;
                            end else begin
                                miso      <= first_bit(words[word_idx]);
                                shift_reg <= shifted(words[word_idx]);
                                state     <= ST_SHIFT;
                            end
`else
                            miso      <= first_bit(words[word_idx]);
                            shift_reg <= shifted(words[word_idx]);
                            state     <= ST_SHIFT;
`endif
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end else if (state == ST_SHIFT) begin
                        if (bit_cnt != BIT_LAST) begin
                            miso      <= first_bit(shift_reg);
                            shift_reg <= shifted(shift_reg);
                            bit_cnt   <= bit_cnt + 1'b1;
                        end else if (word_idx != WORD_LAST) begin
                            word_idx <= nxt_idx;
                            bit_cnt  <= '0;
                            gap_cnt  <= '0;
                            if (GAP_CYCLES > 0) begin
                                miso    <= 1'b0;
                                miso_oe <= 1'b0;
                                state   <= ST_GAP;
                            end else begin
                                miso      <= first_bit(words[nxt_idx]);
                                shift_reg <= shifted(words[nxt_idx]);
                            end
                        end else begin
`ifdef SPI_FRAME_CRC8_EN
                            bit_cnt <= '0;
                            gap_cnt <= '0;
                            if (GAP_CYCLES > 0) begin
                                crc_phase <= 1'b1;
                                miso      <= 1'b0;
                                miso_oe   <= 1'b0;
                                state     <= ST_GAP;
                            end else begin
                                // Last data bit is still on miso, so use the look-ahead CRC.
                                miso   <= crc_nxt[7];
                                crc_sr <= {crc_nxt[6:0], 1'b0};
                                state  <= ST_CRC;
                            end
`else
                            miso       <= 1'b0;
                            miso_oe    <= 1'b0;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                            state      <= ST_DONE;
`endif
                        end
                    end else begin
`ifdef SPI_FRAME_CRC8_EN
                        if (bit_cnt != BW'(7)) begin
                            miso    <= crc_sr[7];
                            crc_sr  <= {crc_sr[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            miso       <= 1'b0;
                            miso_oe    <= 1'b0;
                            busy       <= 1'b0;
                            data_ready <= 1'b1;
                            crc_phase  <= 1'b0;
                            state      <= ST_DONE;
                        end
`else
                        state <= ST_ARMED;
`endif
                    end
                end
                ST_DONE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_tx_slave.sv
// Bench for spi_frame_tx_slave: three configurations sharing sclk/rst, one selected at a time.
// Expected miso/miso_oe streams come from a per-frame bit list built from the frame contents.
module tb_spi_frame_tx_slave;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    logic [1:0]   sel       = 2'd0;
    logic         cs_drv    = 1'b1;
    logic         lv_drv    = 1'b0;
    logic [127:0] frame_drv = '0;
    int   cfg_w = 32;
    int   cfg_n = 4;
    int   cfg_g = 1;
    logic cfg_lsb = 1'b1;

    logic [1:0] exp_q[$];

    logic a_cs, a_lv, a_lr, a_miso, a_oe, a_busy, a_dr;
    logic b_cs, b_lv, b_lr, b_miso, b_oe, b_busy, b_dr;
    logic c_cs, c_lv, c_lr, c_miso, c_oe, c_busy, c_dr;
    logic obs_lr, obs_miso, obs_oe, obs_busy, obs_dr;

    assign a_cs = (sel == 2'd0) ? cs_drv : 1'b1;
    assign b_cs = (sel == 2'd1) ? cs_drv : 1'b1;
    assign c_cs = (sel == 2'd2) ? cs_drv : 1'b1;
    assign a_lv = (sel == 2'd0) && lv_drv;
    assign b_lv = (sel == 2'd1) && lv_drv;
    assign c_lv = (sel == 2'd2) && lv_drv;

    always_comb begin
        obs_lr = a_lr; obs_miso = a_miso; obs_oe = a_oe; obs_busy = a_busy; obs_dr = a_dr;
        if (sel == 2'd1) begin
            obs_lr = b_lr; obs_miso = b_miso; obs_oe = b_oe; obs_busy = b_busy; obs_dr = b_dr;
        end else if (sel == 2'd2) begin
            obs_lr = c_lr; obs_miso = c_miso; obs_oe = c_oe; obs_busy = c_busy; obs_dr = c_dr;
        end
    end

    spi_frame_tx_slave #(.WORD_W(32), .NUM_WORDS(4), .GAP_CYCLES(1), .LSB_FIRST(1)) dut_a (
        .sclk(sclk), .rst(rst), .cs(a_cs), .load_valid(a_lv), .load_ready(a_lr),
        .frame_in(frame_drv), .miso(a_miso), .miso_oe(a_oe), .busy(a_busy), .data_ready(a_dr));

    spi_frame_tx_slave #(.WORD_W(8), .NUM_WORDS(2), .GAP_CYCLES(0), .LSB_FIRST(0)) dut_b (
        .sclk(sclk), .rst(rst), .cs(b_cs), .load_valid(b_lv), .load_ready(b_lr),
        .frame_in(frame_drv[15:0]), .miso(b_miso), .miso_oe(b_oe), .busy(b_busy), .data_ready(b_dr));

    spi_frame_tx_slave #(.WORD_W(8), .NUM_WORDS(1), .GAP_CYCLES(1), .LSB_FIRST(0)) dut_c (
        .sclk(sclk), .rst(rst), .cs(c_cs), .load_valid(c_lv), .load_ready(c_lr),
        .frame_in(frame_drv[7:0]), .miso(c_miso), .miso_oe(c_oe), .busy(c_busy), .data_ready(c_dr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input logic [1:0] s);
        sel = s;
        case (s)
            2'd0:    begin cfg_w = 32; cfg_n = 4; cfg_g = 1; cfg_lsb = 1'b1; end
            2'd1:    begin cfg_w = 8;  cfg_n = 2; cfg_g = 0; cfg_lsb = 1'b0; end
            default: begin cfg_w = 8;  cfg_n = 1; cfg_g = 1; cfg_lsb = 1'b0; end
        endcase
        #1;
    endtask

    // Reference: each word is gap zeros then its bits in send order; optional CRC trailer.
    task automatic build_exp(input logic [127:0] fr);
        logic [7:0]  crc;
        logic [63:0] wd;
        logic        b;
        exp_q.delete();
        crc = 8'h00;
        for (int k = 0; k < cfg_n; k++) begin
            for (int i = 0; i < cfg_g; i++) exp_q.push_back(2'b00);
            wd = 64'(fr >> (k * cfg_w));
            for (int i = 0; i < cfg_w; i++) begin
                b = cfg_lsb ? wd[i] : wd[cfg_w-1-i];
                exp_q.push_back({1'b1, b});
                crc = {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
            end
        end
`ifdef SPI_FRAME_CRC8_EN
        for (int i = 0; i < cfg_g; i++) exp_q.push_back(2'b00);
        for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, crc[i]});
`endif
    endtask

    task automatic check_quiet(input string tag, input logic lr_e, input logic busy_e);
        chk({tag, "_oe"}, obs_oe, 0);
        chk({tag, "_miso"}, obs_miso, 0);
        chk({tag, "_busy"}, obs_busy, busy_e);
        chk({tag, "_dr"}, obs_dr, 0);
        chk({tag, "_lr"}, obs_lr, lr_e);
    endtask

    task automatic do_load(input logic [127:0] fr, input logic hold);
        frame_drv = fr;
        lv_drv = 1'b1;
        chk("pre_load_ready", obs_lr, 1);
        @(posedge sclk); #1;
        lv_drv = hold;
        check_quiet("post_load", 1'b0, 1'b1);
        build_exp(fr);
    endtask

    task automatic run_stream(input int n, input logic scramble);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk); #1;
            chk("miso_oe", obs_oe, exp_q[i][1]);
            chk("miso", obs_miso, exp_q[i][0]);
            chk("busy", obs_busy, 1);
            chk("data_ready", obs_dr, 0);
            if (scramble) frame_drv = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic check_done();
        @(posedge sclk); #1;
        chk("done_pulse", obs_dr, 1);
        chk("done_busy", obs_busy, 0);
        chk("done_oe", obs_oe, 0);
        chk("done_miso", obs_miso, 0);
        lv_drv = 1'b0;
        @(posedge sclk); #1;
        chk("after_done_dr", obs_dr, 0);
        chk("after_done_lr", obs_lr, 1);
        cs_drv = 1'b1;
    endtask

    task automatic full_frame(input logic [127:0] fr, input logic hold);
        do_load(fr, hold);
        repeat (2) begin
            @(posedge sclk); #1;
            check_quiet("armed", 1'b0, 1'b1);
        end
        cs_drv = 1'b0;
        run_stream(exp_q.size(), hold);
        check_done();
    endtask

    initial begin
        int idx;
        int cnt;
        repeat (2) @(posedge sclk);
        #1;
        for (int s = 0; s < 3; s++) begin
            set_sel(2'(s));
            check_quiet("reset", 1'b1, 1'b0);
        end
        rst = 1'b0;
        set_sel(2'd0);

        cs_drv = 1'b0;
        repeat (3) begin
            @(posedge sclk); #1;
            check_quiet("idle_cs_low", 1'b1, 1'b0);
        end
        cs_drv = 1'b1;

        full_frame({32'hFFFFFFFF, 32'h00000000, 32'h12345678, 32'hDEADBEEF}, 1'b1);
        repeat (2) full_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        set_sel(2'd1);
        full_frame({112'h0, 8'h3C, 8'hA5}, 1'b0);
        repeat (3) full_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        set_sel(2'd2);
        full_frame({120'h0, 8'h31}, 1'b0);
        repeat (3) full_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        set_sel(2'd0);
        do_load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idx = 0;
        cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][1] && cnt < 40) begin
                cnt++;
                idx = i;
            end
        end
        cs_drv = 1'b0;
        run_stream(idx + 1, 1'b0);
        cs_drv = 1'b1;
        repeat (3) begin
            @(posedge sclk); #1;
            check_quiet("abort", 1'b0, 1'b1);
        end
        cs_drv = 1'b0;
        run_stream(exp_q.size(), 1'b0);
        check_done();

        do_load({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        cs_drv = 1'b0;
        run_stream(20, 1'b0);
        #2 rst = 1'b1;
        #1 check_quiet("async_rst", 1'b1, 1'b0);
        @(posedge sclk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge sclk); #1;
            check_quiet("post_rst_cs_low", 1'b1, 1'b0);
        end
        cs_drv = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
